data_mem_responder: RTL and testbench

Data-memory responder on the CPU's load/store path. It accepts one word-addressed request at a time from the execute stage, carrying the ALU's 10-bit `ram_address`, store data and byte enables. It performs the access on an internal 32-bit word array after a programmable number of wait states and returns a response through a valid/ready handshake. It is the memory-side end of the interface whose address the ALU computes.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 34 +++
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte write enables and registered read data.
module dmem_array #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  localparam int BE_W = DW / 8;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are deliberately not reset; read data only updates on loads.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, waits WAIT_CYCLES, accesses the
// word array for one cycle, then holds the response until it is taken.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);
  localparam int                BE_W    = DATA_W / 8;
  localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_L  = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                accept, in_range, ram_en;
  logic [DATA_W-1:0]   ram_rdata;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign in_range  = {1'b0, addr_q} < DEPTH_L;
  assign ram_en    = (state_q == ST_ACCESS) && in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        be_q    <= req_be;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = WAIT_L;
          state_d = (WAIT_L != '0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        err_d   = !in_range;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dmem_array #(
    .AW   (RAM_AW),
    .DW   (DATA_W),
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (we_q),
    .be_i   (be_q),
    .addr_i (addr_q[RAM_AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

  // RAM read register is only refreshed in ACCESS, so it is stable through RESP.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: DUT A (DEPTH 512, W=1) and DUT B (DEPTH 1024, W=3).
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        va = 1'b0, vb = 1'b0;
  logic [9:0]  req_addr = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        rdy_a, rv_a, er_a, rdy_b, rv_b, er_b;
  logic [31:0] rd_a, rd_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:511];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(va), .req_ready(rdy_a), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rv_a),
    .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(er_a));

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rdy_b), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rv_b),
    .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(er_b));

  function automatic logic g_rdy(bit s); return s ? rdy_b : rdy_a; endfunction
  function automatic logic g_rv(bit s);  return s ? rv_b  : rv_a;  endfunction
  function automatic logic g_er(bit s);  return s ? er_b  : er_a;  endfunction
  function automatic logic [31:0] g_rd(bit s); return s ? rd_b : rd_a; endfunction

  // One full transaction; hold > 0 stalls the response and pokes a second request.
  task automatic txn(input bit s, input bit we, input logic [9:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    int exp_lat;
    exp_lat = s ? 4 : 2;
    @(negedge clk);
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; rsp_ready = 1'b0;
    if (s) vb = 1'b1; else va = 1'b1;
    checks++;
    if (g_rdy(s) !== 1'b1) begin
      errors++; $display("FAIL ready_before_accept: got %b want 1", g_rdy(s));
    end
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    lat = 0;
    while (g_rv(s) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL latency: got %0d want %0d", lat, exp_lat);
    end
    rd = g_rd(s); er = g_er(s);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        if (s) vb = 1'b1; else va = 1'b1;
        req_addr = a ^ 10'h001;
      end
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      checks++;
      if (g_rv(s) !== 1'b1 || g_rd(s) !== rd || g_er(s) !== er || g_rdy(s) !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: got v=%b d=%h e=%b r=%b want v=1 d=%h e=%b r=0",
                 g_rv(s), g_rd(s), g_er(s), g_rdy(s), rd, er);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (g_rv(s) !== 1'b0 || g_rd(s) !== 32'h0 || g_er(s) !== 1'b0 || g_rdy(s) !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: got v=%b d=%h e=%b r=%b want v=0 d=0 e=0 r=1",
               g_rv(s), g_rd(s), g_er(s), g_rdy(s));
    end
    @(posedge clk); #1;
    checks++;
    if (g_rv(s) !== 1'b0 || g_rdy(s) !== 1'b1) begin
      errors++; $display("FAIL stays_idle: got v=%b r=%b want v=0 r=1", g_rv(s), g_rdy(s));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rv_a !== 1'b0 || rd_a !== 32'h0 || er_a !== 1'b0 || rdy_a !== 1'b0 || rdy_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_values: got v=%b d=%h e=%b ra=%b rb=%b want 0 0 0 0 0",
                 rv_a, rd_a, er_a, rdy_a, rdy_b);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got a=%b b=%b want 1 1", rdy_a, rdy_b);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er;
    txn(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL store_rsp: got d=%h e=%b want d=0 e=0", rd, er);
    end
    txn(0, 0, 10'h005, 4'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL load_after_store: got d=%h e=%b want d=deadbeef e=0", rd, er);
    end
    model[5] = 32'hDEADBEEF;
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic er;
    txn(0, 1, 10'h005, 4'h2, 32'h0000AA00, 0, rd, er);
    txn(0, 0, 10'h005, 4'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL byte_store: got %h want deadaaef", rd);
    end
    txn(0, 1, 10'h005, 4'h0, 32'h12345678, 0, rd, er);
    txn(0, 0, 10'h005, 4'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL zero_be_store: got %h want deadaaef", rd);
    end
    model[5] = 32'hDEADAAEF;
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er;
    txn(0, 0, 10'h005, 4'h0, 32'h0, 5, rd, er);
    checks++;
    if (rd !== 32'hDEADAAEF || er !== 1'b0) begin
      errors++; $display("FAIL backpressure_load: got d=%h e=%b want deadaaef 0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er;
    txn(0, 1, 10'h1FF, 4'hF, 32'hCAFEF00D, 0, rd, er);
    txn(0, 1, 10'h3FF, 4'hF, 32'h12345678, 0, rd, er);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_store: got d=%h e=%b want d=0 e=1", rd, er);
    end
    txn(0, 0, 10'h1FF, 4'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      errors++; $display("FAIL oor_no_alias: got d=%h e=%b want cafef00d 0", rd, er);
    end
    model[511] = 32'hCAFEF00D;
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp_d; logic er, exp_e, we;
    logic [9:0] a; logic [3:0] be;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      txn(0, 1, 10'(32 + i), 4'hF, wd, 0, rd, er);
      model[32 + i] = wd;
    end
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) a = 10'(512 + $urandom_range(0, 511));
      else a = 10'(32 + $urandom_range(0, 7));
      exp_e = (a >= 10'd512);
      exp_d = 32'h0;
      if (!exp_e && !we) exp_d = model[a];
      txn(0, we, a, be, wd, $urandom_range(0, 3), rd, er);
      if (!exp_e && we) begin
        for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = wd[8*b +: 8];
      end
      checks++;
      if (rd !== exp_d || er !== exp_e) begin
        errors++;
        $display("FAIL random_op%0d: addr=%h we=%b got d=%h e=%b want d=%h e=%b",
                 n, a, we, rd, er, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er;
    txn(1, 1, 10'h010, 4'hF, 32'h22222222, 0, rd, er);
    @(negedge clk);
    req_we = 1'b1; req_addr = 10'h010; req_be = 4'hF; req_wdata = 32'h11111111;
    vb = 1'b1;
    @(posedge clk); #1;
    vb = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rv_b !== 1'b0 || rdy_b !== 1'b0) begin
        errors++; $display("FAIL abort_in_reset: got v=%b r=%b want 0 0", rv_b, rdy_b);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rv_b !== 1'b0 || rdy_b !== 1'b1) begin
        errors++; $display("FAIL abort_no_rsp: got v=%b r=%b want v=0 r=1", rv_b, rdy_b);
      end
    end
    txn(1, 0, 10'h010, 4'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'h22222222 || er !== 1'b0) begin
      errors++; $display("FAIL abort_store_dropped: got d=%h e=%b want 22222222 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
